// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the RAM port arbiter.
// Carries N_REQ packed command channels (valid/we/lock/addr/wdata), the
// one-hot grant back to the requesters, and the shared read-return path
// (one-hot rvalid plus a single rdata bus).
//   master : requester side (drives commands, receives gnt/rvalid/rdata)
//   slave  : arbiter side   (receives commands, drives gnt/rvalid/rdata)
interface ram_port_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ-1:0]        req_lock;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]       rdata;

    modport master (
        output req, req_we, req_lock, req_addr, req_wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, req_we, req_lock, req_addr, req_wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one port of a 512x8 true-dual-port RAM among
// N_REQ requesters. One beat per cycle is accepted (req & gnt at posedge),
// turned into a registered one-cycle wren/rden pulse with address/data, and
// read data is returned two cycles after acceptance with a one-hot rvalid.
// A requester may hold the port with req_lock for up to MAX_BURST beats.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req_bus       requester command/grant/read-return bus (slave side)
//   ram_wren/rden registered RAM command strobes
//   ram_address   registered RAM address (holds when no command)
//   ram_data      registered RAM write data (holds when no command)
//   ram_q         RAM read data, passed straight through to rdata
//   busy          locked, or a command / read return still in the pipe
module ram_port_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    ram_port_arbiter_if.slave   req_bus,
    output logic                ram_wren,
    output logic                ram_rden,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W-1:0]   ram_data,
    input  logic [DATA_W-1:0]   ram_q,
    output logic                busy
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_r, state_nx_s;
    logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_nx_s;
    logic [IDX_W-1:0]   owner_r, owner_nx_s;
    logic [CNT_W-1:0]   beat_cnt_r, beat_cnt_nx_s;
    logic [IDX_W-1:0]   sel_idx_s;
    logic               sel_hit_s;
    logic [N_REQ-1:0]   gnt_s;
    logic               ram_wren_r, ram_rden_r;
    logic [ADDR_W-1:0]  ram_address_r;
    logic [DATA_W-1:0]  ram_data_r;
    logic [IDX_W-1:0]   rd_tag_r;
    logic [N_REQ-1:0]   rvalid_r;

    // (base + off) mod N_REQ without a divider; both operands are < N_REQ
    function automatic int wrap_idx(input int base_i, input int off_i);
        int sum_v;
        sum_v = base_i + off_i;
        if (sum_v >= N_REQ) begin
            sum_v = sum_v - N_REQ;
        end else begin
            sum_v = sum_v;
        end
        return sum_v;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx_i);
        if (int'(idx_i) == N_REQ - 1) begin
            return '0;
        end else begin
            return idx_i + IDX_W'(1);
        end
    endfunction

    function automatic logic [N_REQ-1:0] one_hot(input logic [IDX_W-1:0] idx_i);
        logic [N_REQ-1:0] vec_v;
        vec_v = '0;
        vec_v[idx_i] = 1'b1;
        return vec_v;
    endfunction

    // Grant selection: rotating search from rr_ptr when idle, owner only when locked.
    // The search runs from the far end back to rr_ptr so the closest requester wins.
    always_comb begin
        sel_idx_s = '0;
        sel_hit_s = 1'b0;
        gnt_s     = '0;
        case (state_r)
            ST_IDLE: begin
                for (int k = N_REQ - 1; k >= 0; k--) begin
                    sel_idx_s = req_bus.req[wrap_idx(int'(rr_ptr_r), k)]
                              ? IDX_W'(wrap_idx(int'(rr_ptr_r), k)) : sel_idx_s;
                    sel_hit_s = sel_hit_s | req_bus.req[wrap_idx(int'(rr_ptr_r), k)];
                end
            end
            ST_LOCKED: begin
                sel_idx_s = owner_r;
                sel_hit_s = req_bus.req[owner_r];
            end
            default: begin
                sel_idx_s = '0;
                sel_hit_s = 1'b0;
            end
        endcase
        if (sel_hit_s) begin
            gnt_s[sel_idx_s] = 1'b1;
        end else begin
            gnt_s = '0;
        end
    end

    // Next-state for ownership, round-robin pointer and burst counter.
    always_comb begin
        state_nx_s    = state_r;
        rr_ptr_nx_s   = rr_ptr_r;
        owner_nx_s    = owner_r;
        beat_cnt_nx_s = beat_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (sel_hit_s) begin
                    rr_ptr_nx_s = next_idx(sel_idx_s);
                    // A one-beat burst limit means a locking beat is already the last one
                    if (req_bus.req_lock[sel_idx_s] && (MAX_BURST > 1)) begin
                        state_nx_s    = ST_LOCKED;
                        owner_nx_s    = sel_idx_s;
                        beat_cnt_nx_s = CNT_W'(1);
                    end else begin
                        state_nx_s    = ST_IDLE;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (sel_hit_s) begin
                    // This beat is performed even when it is the one that hits the limit
                    if (!req_bus.req_lock[owner_r] ||
                        (beat_cnt_r >= CNT_W'(MAX_BURST - 1))) begin
                        state_nx_s    = ST_IDLE;
                        rr_ptr_nx_s   = next_idx(owner_r);
                        beat_cnt_nx_s = '0;
                    end else begin
                        beat_cnt_nx_s = beat_cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_nx_s = ST_LOCKED;
                end
            end
            default: begin
                state_nx_s    = ST_IDLE;
                beat_cnt_nx_s = '0;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= '0;
            owner_r    <= '0;
            beat_cnt_r <= '0;
        end else begin
            state_r    <= state_nx_s;
            rr_ptr_r   <= rr_ptr_nx_s;
            owner_r    <= owner_nx_s;
            beat_cnt_r <= beat_cnt_nx_s;
        end
    end

    // RAM command stage and two-stage read tag: the tag rides with rden in t+1
    // and becomes the rvalid pulse in t+2, when ram_q carries the read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_wren_r    <= 1'b0;
            ram_rden_r    <= 1'b0;
            ram_address_r <= '0;
            ram_data_r    <= '0;
            rd_tag_r      <= '0;
            rvalid_r      <= '0;
        end else begin
            ram_wren_r <= sel_hit_s &  req_bus.req_we[sel_idx_s];
            ram_rden_r <= sel_hit_s & ~req_bus.req_we[sel_idx_s];
            if (sel_hit_s) begin
                ram_address_r <= req_bus.req_addr[int'(sel_idx_s)*ADDR_W +: ADDR_W];
                ram_data_r    <= req_bus.req_wdata[int'(sel_idx_s)*DATA_W +: DATA_W];
                rd_tag_r      <= sel_idx_s;
            end else begin
                ram_address_r <= ram_address_r;
                ram_data_r    <= ram_data_r;
                rd_tag_r      <= rd_tag_r;
            end
            rvalid_r <= ram_rden_r ? one_hot(rd_tag_r) : '0;
        end
    end

    assign req_bus.gnt    = gnt_s;
    assign req_bus.rvalid = rvalid_r;
    assign req_bus.rdata  = ram_q;
    assign ram_wren       = ram_wren_r;
    assign ram_rden       = ram_rden_r;
    assign ram_address    = ram_address_r;
    assign ram_data       = ram_data_r;
    assign busy           = (state_r == ST_LOCKED) | ram_wren_r | ram_rden_r | (|rvalid_r);
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a behavioural RAM, a transaction-level reference
// model (priority list, expected memory, queue of due read returns), a table
// of grant vectors, directed multi-cycle sequences and a randomized phase.
module tb_ram_port_arbiter;
    localparam int N_REQ     = 4;
    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 8;

    logic              clk;
    logic              rst_n;
    logic              ram_wren, ram_rden, busy;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] ram_q;

    ram_port_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_port_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_bus(bus),
        .ram_wren(ram_wren),
        .ram_rden(ram_rden),
        .ram_address(ram_address),
        .ram_data(ram_data),
        .ram_q(ram_q),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port view of the RAM: registered q, one-cycle latency
    logic [DATA_W-1:0] mem [0:511];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        if (ram_rden) ram_q <= mem[ram_address];
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [N_REQ-1:0]  tb_req, tb_we, tb_lock;
    logic [ADDR_W-1:0] tb_addr  [N_REQ];
    logic [DATA_W-1:0] tb_wdata [N_REQ];

    // Reference model state
    bit                m_locked;
    int                m_owner, m_cnt, m_ptr;
    logic [DATA_W-1:0] exp_mem [512];
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    typedef struct { int due; int idx; logic [DATA_W-1:0] data; } rd_t;
    rd_t pend[$];

    typedef struct {
        logic [N_REQ-1:0] req;
        logic [N_REQ-1:0] lock;
        logic [N_REQ-1:0] we;
        logic [N_REQ-1:0] exp_gnt;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_addr[i*ADDR_W +: ADDR_W]  = tb_addr[i];
            bus.req_wdata[i*DATA_W +: DATA_W] = tb_wdata[i];
        end
        bus.req      = tb_req;
        bus.req_we   = tb_we;
        bus.req_lock = tb_lock;
    endtask

    function automatic int model_pick();
        if (m_locked) return tb_req[m_owner] ? m_owner : -1;
        for (int k = 0; k < N_REQ; k++)
            if (tb_req[(m_ptr + k) % N_REQ]) return (m_ptr + k) % N_REQ;
        return -1;
    endfunction

    task automatic model_accept(input int g);
        if (!m_locked) begin
            m_ptr = (g + 1) % N_REQ;
            if (tb_lock[g] && MAX_BURST > 1) begin
                m_locked = 1'b1; m_owner = g; m_cnt = 1;
            end
        end else begin
            m_cnt++;
            if (!tb_lock[g] || m_cnt >= MAX_BURST) begin
                m_locked = 1'b0; m_ptr = (g + 1) % N_REQ;
            end
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0; m_owner = 0; m_cnt = 0; m_ptr = 0;
        exp_addr = '0; exp_data = '0;
        pend.delete();
    endtask

    // One clock cycle: starts at a negedge with tb_* set, ends at the next negedge
    task automatic do_cycle();
        int g;
        logic [N_REQ-1:0]  exp_gnt, exp_rv;
        logic              exp_wr, exp_rd;
        logic [DATA_W-1:0] exp_q;
        bit                rv_any;
        drive_inputs();
        #1;
        g = model_pick();
        exp_gnt = '0;
        if (g >= 0) exp_gnt[g] = 1'b1;
        check("gnt", bus.gnt, exp_gnt);
        exp_wr = 1'b0; exp_rd = 1'b0;
        if (g >= 0) begin
            exp_wr   = tb_we[g];
            exp_rd   = !tb_we[g];
            exp_addr = tb_addr[g];
            exp_data = tb_wdata[g];
            if (tb_we[g]) exp_mem[tb_addr[g]] = tb_wdata[g];
            else pend.push_back('{due: cyc + 2, idx: g, data: exp_mem[tb_addr[g]]});
            model_accept(g);
        end
        @(posedge clk);
        cyc++;
        #1;
        check("ram_wren", ram_wren, exp_wr);
        check("ram_rden", ram_rden, exp_rd);
        check("ram_address", ram_address, exp_addr);
        check("ram_data", ram_data, exp_data);
        exp_rv = '0; exp_q = '0; rv_any = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            exp_rv[pend[0].idx] = 1'b1;
            exp_q  = pend[0].data;
            rv_any = 1'b1;
            pend.delete(0);
        end
        check("rvalid", bus.rvalid, exp_rv);
        if (rv_any) check("rdata", bus.rdata, exp_q);
        else        check("busy", busy, m_locked | exp_wr | exp_rd);
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        tb_req = '0; tb_we = '0; tb_lock = '0;
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    // Asserts reset off-edge, checks outputs clear at once, holds over one edge
    task automatic apply_reset();
        tb_req = '0; tb_we = '0; tb_lock = '0;
        drive_inputs();
        rst_n = 1'b0;
        #1;
        check("rst_wren", ram_wren, 1'b0);
        check("rst_rden", ram_rden, 1'b0);
        check("rst_addr", ram_address, '0);
        check("rst_data", ram_data, '0);
        check("rst_rvalid", bus.rvalid, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_gnt_idle", bus.gnt, '0);
        tb_req = 4'b0110;
        drive_inputs();
        #1;
        check("rst_gnt_follow", bus.gnt, 4'b0010);
        tb_req = '0;
        drive_inputs();
        @(posedge clk);
        cyc++;
        #1;
        check("rst_no_rvalid", bus.rvalid, '0);
        check("rst_no_rden", ram_rden, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_REQ-1:0]  pl_rv [5];
        logic [DATA_W-1:0] pl_q  [5];
        rst_n = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            tb_addr[i] = '0; tb_wdata[i] = '0;
        end
        tb_req = '0; tb_we = '0; tb_lock = '0;
        drive_inputs();
        model_reset();
        #1;
        apply_reset();

        // Fill the whole RAM through requester 0 so every later read has a known value
        for (int a = 0; a < 512; a++) begin
            tb_req = 4'b0001; tb_we = 4'b0001; tb_lock = '0;
            tb_addr[0]  = ADDR_W'(a);
            tb_wdata[0] = DATA_W'(a) ^ 8'hA5;
            do_cycle();
        end
        idle_cycles(2);
        apply_reset();

        // Grant table from a fresh reset (rr_ptr = 0)
        for (int r = 0; r < 8; r++)
            vecs.push_back('{4'b1111, 4'b0000, 4'b0101, 4'b0001 << (r % 4)});
        vecs.push_back('{4'b0110, 4'b0010, 4'b0000, 4'b0010});
        vecs.push_back('{4'b0110, 4'b0010, 4'b0000, 4'b0010});
        vecs.push_back('{4'b0110, 4'b0010, 4'b0000, 4'b0010});
        vecs.push_back('{4'b0110, 4'b0000, 4'b0000, 4'b0010});
        vecs.push_back('{4'b0100, 4'b0000, 4'b0000, 4'b0100});
        vecs.push_back('{4'b0010, 4'b0010, 4'b0000, 4'b0010});
        vecs.push_back('{4'b0100, 4'b0000, 4'b0000, 4'b0000});
        vecs.push_back('{4'b0010, 4'b0000, 4'b0000, 4'b0010});
        for (int r = 0; r < 8; r++)
            vecs.push_back('{4'b1001, 4'b1000, 4'b0000, 4'b1000});
        vecs.push_back('{4'b1001, 4'b1000, 4'b0000, 4'b0001});
        vecs.push_back('{4'b1000, 4'b0000, 4'b0000, 4'b1000});
        for (int v = 0; v < vecs.size(); v++) begin
            tb_req = vecs[v].req; tb_lock = vecs[v].lock; tb_we = vecs[v].we;
            for (int i = 0; i < N_REQ; i++) begin
                tb_addr[i]  = ADDR_W'($urandom_range(0, 511));
                tb_wdata[i] = DATA_W'($urandom);
            end
            drive_inputs();
            #1;
            check($sformatf("tbl_gnt[%0d]", v), bus.gnt, vecs[v].exp_gnt);
            do_cycle();
        end
        idle_cycles(3);

        // Write 0x3C to 0x1A5, read it back: rvalid[0] two cycles after the read accept
        tb_req = 4'b0001; tb_we = 4'b0001; tb_lock = '0;
        tb_addr[0] = 9'h1A5; tb_wdata[0] = 8'h3C;
        do_cycle();
        tb_we = 4'b0000;
        do_cycle();
        tb_req = '0;
        do_cycle();
        check("wr_rd_rvalid", bus.rvalid, 4'b0001);
        check("wr_rd_rdata", bus.rdata, 8'h3C);
        idle_cycles(2);

        // Requester 2 preloads 0x10..0x12 at 0..2, then reads them back-to-back
        for (int k = 0; k < 3; k++) begin
            tb_req = 4'b0100; tb_we = 4'b0100;
            tb_addr[2] = ADDR_W'(k); tb_wdata[2] = 8'h10 + DATA_W'(k);
            do_cycle();
        end
        pl_rv[0] = 4'b0000; pl_rv[1] = 4'b0100; pl_rv[2] = 4'b0100;
        pl_rv[3] = 4'b0100; pl_rv[4] = 4'b0000;
        pl_q[1] = 8'h10; pl_q[2] = 8'h11; pl_q[3] = 8'h12;
        for (int k = 0; k < 5; k++) begin
            tb_req = (k < 3) ? 4'b0100 : 4'b0000; tb_we = '0;
            tb_addr[2] = ADDR_W'(k);
            do_cycle();
            check($sformatf("pipe_rvalid[%0d]", k), bus.rvalid, pl_rv[k]);
            if (k >= 1 && k <= 3) check($sformatf("pipe_rdata[%0d]", k), bus.rdata, pl_q[k]);
        end

        // Randomized traffic on a small address window to exercise write-then-read
        for (int n = 0; n < 400; n++) begin
            tb_req  = N_REQ'($urandom_range(0, 15));
            tb_we   = N_REQ'($urandom_range(0, 15));
            tb_lock = N_REQ'($urandom_range(0, 15) & $urandom_range(0, 15));
            for (int i = 0; i < N_REQ; i++) begin
                tb_addr[i]  = ADDR_W'($urandom_range(0, 31));
                tb_wdata[i] = DATA_W'($urandom);
            end
            do_cycle();
        end
        idle_cycles(3);

        // Reset while a read is on the RAM port: the beat is dropped, no rvalid
        tb_req = 4'b0001; tb_we = '0; tb_lock = '0; tb_addr[0] = 9'h1A5;
        do_cycle();
        apply_reset();
        idle_cycles(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
